// File: rtl/sha3_pkg.sv
// sha3_pkg: shared types and constants for the SHA-3 sponge controller (KECCAK_LEGACY_PAD_EN selects Keccak padding)
package sha3_pkg;

    typedef enum logic [1:0] {FILL, PAD, ABSORB, DONE} sha3_ctrl_state_t;

`ifdef KECCAK_LEGACY_PAD_EN
    localparam logic [7:0] SHA3_PAD_FIRST = 8'h01;
`else
    localparam logic [7:0] SHA3_PAD_FIRST = 8'h06;
`endif
    localparam logic [7:0] SHA3_PAD_LAST = 8'h80;

    function automatic int sha3_rate(input int d);
        return 1600 - 2 * d;
    endfunction

endpackage

// File: rtl/sha3_sponge_ctrl_if.sv
// sha3_sponge_ctrl_if: byte stream, digest and keccak core signals of the sponge controller
interface sha3_sponge_ctrl_if #(
    parameter int D = 256,
    parameter int R = 1600 - 2 * D
);
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic         digest_valid;
    logic         digest_ready;
    logic [D-1:0] digest;
    logic         core_init;
    logic         core_start;
    logic [R-1:0] core_block;
    logic         core_done;
    logic [D-1:0] core_digest;

    modport slave (
        input  in_valid, in_data, in_last, in_empty, digest_ready, core_done, core_digest,
        output in_ready, digest_valid, digest, core_init, core_start, core_block
    );

    modport master (
        output in_valid, in_data, in_last, in_empty, digest_ready, core_done, core_digest,
        input  in_ready, digest_valid, digest, core_init, core_start, core_block
    );
endinterface

// File: rtl/sha3_pad_gen.sv
// sha3_pad_gen: applies multi-rate padding to a partially filled rate block starting at byte idx_i
module sha3_pad_gen import sha3_pkg::*; #(
    parameter int R = 1088
) (
    input  logic [$clog2(R/8+1)-1:0] idx_i,
    input  logic [R-1:0]             blk_i,
    output logic [R-1:0]             blk_o
);
    localparam int RB = R / 8;

    // keep data below idx, drop the rest, then xor in the first and last pad bytes (they merge when idx is RB-1)
    always_comb begin
        blk_o = '0;
        for (int k = 0; k < RB; k++)
            blk_o[8*k +: 8] = (k < int'(idx_i) ? blk_i[8*k +: 8] : 8'h00)
                            ^ (k == int'(idx_i) ? SHA3_PAD_FIRST : 8'h00)
                            ^ (k == RB - 1 ? SHA3_PAD_LAST : 8'h00);
    end
endmodule

// File: rtl/sha3_sponge_ctrl.sv
// sha3_sponge_ctrl: packs a byte stream into rate blocks, pads, sequences keccak absorbs and returns the digest (KECCAK_LEGACY_PAD_EN selects Keccak padding)
module sha3_sponge_ctrl import sha3_pkg::*; #(
    parameter int D = 256,
    parameter int R = sha3_rate(D)
) (
    input logic               clk,
    input logic               reset_n,
    sha3_sponge_ctrl_if.slave bus
);
    localparam int RB = R / 8;
    localparam int IW = $clog2(RB + 1);
    localparam logic [IW-1:0] RB_I = IW'(RB);

    sha3_ctrl_state_t state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d, idx_inc;
    logic [R-1:0]     buf_q, buf_d, padded;
    logic [D-1:0]     dig_q, dig_d;
    logic             final_q, final_d, pend_q, pend_d;
    logic             start_q, start_d, init_q, init_d, rdy_q, rdy_d;
    logic             take, write, done_ok, full;

    sha3_pad_gen #(.R(R)) u_pad (.idx_i(idx_q), .blk_i(buf_q), .blk_o(padded));

    assign take    = bus.in_valid & rdy_q;
    assign write   = !(bus.in_last && bus.in_empty);
    assign idx_inc = idx_q + IW'(1);
    assign full    = idx_inc == RB_I;
    assign done_ok = state_q == ABSORB && !start_q && bus.core_done;

    assign bus.in_ready     = rdy_q;
    assign bus.digest_valid = state_q == DONE;
    assign bus.digest       = dig_q;
    assign bus.core_init    = init_q;
    assign bus.core_start   = start_q;
    assign bus.core_block   = buf_q;

    // next state: byte packing, padding, absorb sequencing and digest handoff
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        final_d = final_q;
        pend_d  = pend_q;
        dig_d   = dig_q;
        case (state_q)
            FILL: if (take) begin
                if (write) begin
                    buf_d[{idx_q, 3'b000} +: 8] = bus.in_data;
                    idx_d = idx_inc;
                end
                state_d = (write && full) ? ABSORB : bus.in_last ? PAD : FILL;
                pend_d  = write && full && bus.in_last;
            end
            PAD: begin
                buf_d   = padded;
                final_d = 1'b1;
                pend_d  = 1'b0;
                state_d = ABSORB;
            end
            ABSORB: if (done_ok) begin
                state_d = final_q ? DONE : pend_q ? PAD : FILL;
                dig_d   = final_q ? bus.core_digest : dig_q;
                buf_d   = final_q ? buf_q : '0;
                idx_d   = final_q ? idx_q : '0;
            end
            DONE: if (bus.digest_ready) begin
                state_d = FILL;
                buf_d   = '0;
                idx_d   = '0;
                final_d = 1'b0;
            end
            default: state_d = FILL;
        endcase
        start_d = state_d == ABSORB && state_q != ABSORB;
        init_d  = state_q == DONE && bus.digest_ready;
        rdy_d   = state_d == FILL;
    end

    // state register; reset aborts any message in flight and clears the core
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            buf_q   <= '0;
            dig_q   <= '0;
            final_q <= 1'b0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            init_q  <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            dig_q   <= dig_d;
            final_q <= final_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            init_q  <= init_d;
            rdy_q   <= rdy_d;
        end
    end
endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// tb_sha3_sponge_ctrl: table vectors, hand sequences and random messages against a padding/absorb reference model
module tb_sha3_sponge_ctrl;
    localparam int D  = 256;
    localparam int R  = 1600 - 2 * D;
    localparam int RB = R / 8;
`ifdef KECCAK_LEGACY_PAD_EN
    localparam byte unsigned PF = 8'h01;
`else
    localparam byte unsigned PF = 8'h06;
`endif

    typedef logic [R-1:0] blk_t;
    typedef byte unsigned msg_t[$];
    typedef struct {
        int           len;
        byte unsigned base;
        int           nblk;
        int           pad_pos;
        byte unsigned pad_val;
        byte unsigned last_val;
    } vec_t;

    logic   clk = 1'b1;
    logic   reset_n = 1'b0;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    blk_t   obs_q[$];
    int     start_cyc[$];
    blk_t   cur_blk;
    blk_t   s_st = '0;
    int     cnt = 0;
    int     last_cyc = 0;
    vec_t   tbl[7];

    sha3_sponge_ctrl_if #(.D(D)) bus();
    sha3_sponge_ctrl #(.D(D)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic chk_blk(input string nm, input blk_t act, input blk_t exp);
        int k;
        k = 0;
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            while (k < RB - 1 && act[8*k +: 8] === exp[8*k +: 8]) k++;
            $display("FAIL %s byte %0d: got %h want %h", nm, k, act[8*k +: 8], exp[8*k +: 8]);
        end
    endtask

    // Keccak core stand-in: random latency, spurious done pulses where they must be ignored,
    // digest = running rotate-xor of all absorbed blocks since the last init
    always @(negedge clk) begin
        if (bus.core_init) s_st = '0;
        if (bus.core_start) begin
            obs_q.push_back(bus.core_block);
            start_cyc.push_back(cyc);
            cur_blk = bus.core_block;
            s_st = {s_st[R-2:0], s_st[R-1]} ^ bus.core_block;
            cnt = $urandom_range(4, 1);
            bus.core_done = 1'($urandom_range(1));
        end else if (cnt > 0) begin
            cnt--;
            bus.core_done = (cnt == 0);
            if (cnt == 0) chk_blk("block_stable", bus.core_block, cur_blk);
        end else bus.core_done = ($urandom_range(3) == 0);
        bus.core_digest = s_st[D-1:0];
    end

    function automatic void build(input msg_t msg, output blk_t blks[$]);
        msg_t p;
        int q;
        blk_t x;
        p = msg;
        q = RB - (msg.size() % RB);
        if (q == 1) p.push_back(PF | 8'h80);
        else begin
            p.push_back(PF);
            for (int k = 0; k < q - 2; k++) p.push_back(8'h00);
            p.push_back(8'h80);
        end
        blks.delete();
        for (int b = 0; b < p.size() / RB; b++) begin
            x = '0;
            for (int k = 0; k < RB; k++) x[8*k +: 8] = p[b*RB + k];
            blks.push_back(x);
        end
    endfunction

    function automatic logic [D-1:0] model_digest(input blk_t b[$]);
        blk_t s;
        s = '0;
        foreach (b[i]) s = {s[R-2:0], s[R-1]} ^ b[i];
        return s[D-1:0];
    endfunction

    task automatic run_msg(input msg_t msg, input int gap, input int hold);
        blk_t exp[$];
        int n, beats, i, g, li, lat;
        logic [D-1:0] d0;
        n = msg.size();
        beats = (n == 0) ? 1 : n;
        i = 0;
        g = 0;
        build(msg, exp);
        obs_q.delete();
        start_cyc.delete();
        while (i < beats && g < 20000) begin
            @(negedge clk);
            g++;
            bus.digest_ready = 1'($urandom_range(1));
            if ($urandom_range(99) >= gap) begin
                bus.in_valid = 1'b1;
                bus.in_data  = (n == 0) ? 8'($urandom) : msg[i];
                bus.in_last  = (i == beats - 1);
                bus.in_empty = (n == 0);
                if (bus.in_ready) begin
                    if (i == beats - 1) last_cyc = cyc;
                    i++;
                end
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'($urandom);
                bus.in_empty = 1'($urandom);
            end
        end
        chk("send_done", i, beats);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.digest_ready = 1'b0;
        g = 0;
        while (!bus.digest_valid && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("digest_valid", bus.digest_valid, 1);
        chk("n_blocks", obs_q.size(), exp.size());
        foreach (exp[k]) if (k < obs_q.size()) chk_blk("block", obs_q[k], exp[k]);
        chk("digest", bus.digest, model_digest(exp));
        li = (n > 0 && n % RB == 0) ? exp.size() - 2 : exp.size() - 1;
        lat = (li < start_cyc.size()) ? start_cyc[li] - last_cyc : -1;
        chk("start_latency", lat, (n > 0 && n % RB == 0) ? 1 : 2);
        d0 = bus.digest;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("hold_valid", bus.digest_valid, 1);
            chk("hold_digest", bus.digest, d0);
        end
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
        chk("init_pulse", bus.core_init, 1);
        chk("valid_drop", bus.digest_valid, 0);
        @(negedge clk);
        chk("init_end", bus.core_init, 0);
    endtask

    initial begin
        msg_t m;
        blk_t lb;
        int i, g;
        tbl[0] = '{0,   8'h00, 1, 0,   PF,         8'h80};
        tbl[1] = '{3,   8'h61, 1, 3,   PF,         8'h80};
        tbl[2] = '{135, 8'h10, 1, 135, PF | 8'h80, PF | 8'h80};
        tbl[3] = '{136, 8'h20, 2, 0,   PF,         8'h80};
        tbl[4] = '{137, 8'h30, 2, 1,   PF,         8'h80};
        tbl[5] = '{271, 8'h40, 2, 135, PF | 8'h80, PF | 8'h80};
        tbl[6] = '{272, 8'h50, 3, 0,   PF,         8'h80};
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_last = 1'b0;
        bus.in_empty = 1'b0;
        bus.digest_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_digest_valid", bus.digest_valid, 0);
        chk("rst_digest", bus.digest, 0);
        chk("rst_core_start", bus.core_start, 0);
        chk("rst_core_init", bus.core_init, 1);
        chk_blk("rst_core_block", bus.core_block, '0);
        reset_n = 1'b1;
        #1;
        chk("rel_core_init", bus.core_init, 1);
        chk("rel_in_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("post_core_init", bus.core_init, 0);
        chk("post_in_ready", bus.in_ready, 1);

        for (int t = 0; t < 7; t++) begin
            m.delete();
            for (int k = 0; k < tbl[t].len; k++) m.push_back(8'(tbl[t].base + k));
            run_msg(m, (t % 2) ? 30 : 0, t);
            chk("tbl_nblk", obs_q.size(), tbl[t].nblk);
            if (obs_q.size() > 0) begin
                lb = obs_q[obs_q.size() - 1];
                chk("tbl_pad_byte", lb[8*tbl[t].pad_pos +: 8], tbl[t].pad_val);
                chk("tbl_last_byte", lb[8*(RB-1) +: 8], tbl[t].last_val);
            end
        end

        i = 0;
        g = 0;
        while (i < 50 && g < 1000) begin
            @(negedge clk);
            g++;
            bus.in_valid = 1'b1;
            bus.in_data = 8'($urandom);
            bus.in_last = 1'b0;
            bus.in_empty = 1'b0;
            if (bus.in_ready) i++;
        end
        chk("partial_sent", i, 50);
        @(negedge clk);
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_core_init", bus.core_init, 1);
        chk("mid_rst_digest_valid", bus.digest_valid, 0);
        reset_n = 1'b1;
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 0, 0);
        lb = (obs_q.size() > 0) ? obs_q[0] : '0;
        chk("abc_b0", lb[7:0], 8'h61);
        chk("abc_b3", lb[31:24], PF);
        chk("abc_b135", lb[8*(RB-1) +: 8], 8'h80);

        m.delete();
        for (int k = 0; k < 300; k++) m.push_back(8'($urandom));
        run_msg(m, 40, 10);
        chk("long_nblk", obs_q.size(), 3);
        m.delete();
        for (int k = 0; k < 20; k++) m.push_back(8'($urandom));
        run_msg(m, 20, 0);

        for (int t = 0; t < 5; t++) begin
            m.delete();
            repeat ($urandom_range(280)) m.push_back(8'($urandom));
            run_msg(m, $urandom_range(50), $urandom_range(4));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sha3_sponge_ctrl.md
# sha3_sponge_ctrl

Byte-stream front end and sequencer for the `keccak` sponge core. It accepts message bytes over a valid/ready handshake and packs them into R-bit rate blocks. It applies SHA-3 multi-rate padding, issues one absorb request per block to the core, and presents the D-bit digest over a valid/ready handshake. It sits between the host/DMA byte source and the `keccak` core, replacing testbench-side chunking and padding.

## Interface
- `D`, 256: digest width in bits (224/256/384/512).
- `R`, 1600-2*D: rate in bits; localparam `RB = R/8` is bytes per block (136 for D=256).
- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: controller accepts a byte.
- `in_data` in 8: message byte.
- `in_last` in 1: qualifies the final beat of a message.
- `in_empty` in 1: with `in_last`, this beat carries no data byte (zero-length tail).
- `digest_valid` out 1: digest available.
- `digest_ready` in 1: consumer accepts digest.
- `digest` out D: result hash.
- `core_init` out 1: clears the core state.
- `core_start` out 1: one-cycle absorb request.
- `core_block` out R: rate block to XOR/absorb.
- `core_done` in 1: core finished permutation for the current block.
- `core_digest` in D: core's truncated state.

## Operation
- Byte k of a block occupies `core_block[8k+7:8k]` (FIPS 202 lane order).
- States: FILL, PAD, ABSORB, DONE. Reset enters FILL with idx=0 and the buffer cleared.
- FILL: `in_ready`=1. Each accepted beat with `in_empty`=0 writes `in_data` at idx and increments idx.
  - idx reaches RB, not last: go to ABSORB (non-final).
  - Last beat with idx<RB after the write (or `in_empty`): go to PAD.
  - Last beat that fills idx to RB exactly: go to ABSORB with `pad_pending`=1.
- PAD (1 cycle): byte idx ^= 0x06; byte RB-1 ^= 0x80; bytes idx+1..RB-2 = 0x00. If idx==RB-1, that byte is 0x86. Mark final, then go to ABSORB.
- ABSORB: `core_start` pulses in the first cycle. `core_block` stays stable until `core_done`. On `core_done`:
  - Final block: capture `core_digest` and go to DONE.
  - `pad_pending`: clear the buffer, set idx=0, go to PAD (pad-only block).
  - Otherwise: clear the buffer, set idx=0, go to FILL.
- DONE: `digest_valid`=1, `digest` held. On `digest_ready`: pulse `core_init` for 1 cycle and go to FILL for the next message.

## Timing
- Reset values while `reset_n`=0 and in the first cycle after: `in_ready`=0, `digest_valid`=0, `digest`=0, `core_start`=0, `core_block`=0, `core_init`=1. `core_init` deasserts on the first cycle after reset release.
- `in_ready` is registered and asserted only in FILL. There is no combinational path from `in_valid` to `in_ready`.
- A byte transfers on `in_valid & in_ready`. Stall without loss for any run of `in_valid`=0.
- Latency from the last beat to `core_start`: 2 cycles via PAD, 1 cycle if the block was full.
- `core_done` is ignored in the `core_start` cycle and outside ABSORB. The earliest valid `core_done` is the following cycle.
- Digest latency: last beat + 2 + core latency (+ 1 + core latency if a pad-only block is needed).
- `digest_valid` and `digest` hold until accepted. `digest_ready` outside DONE is ignored.
- `reset_n` low mid-message aborts it: buffer, idx and flags are cleared, and `core_init` is asserted. Partial input is discarded.

## Configuration
- `KECCAK_LEGACY_PAD_EN` defined: the domain/pad start byte is 0x01 (original Keccak), and a single-byte pad is 0x81.
- Undefined (default): SHA-3 domain byte 0x06, and a single-byte pad is 0x86. No other behaviour changes.

## Structure
- Package `sha3_pkg`:
  - state enum `sha3_ctrl_state_t`;
  - constants `SHA3_PAD_FIRST` (0x06/0x01, per macro) and `SHA3_PAD_LAST` (0x80);
  - function computing R from D.
- One sub-module, `sha3_pad_gen`: combinational. Given idx and the buffer, it produces the padded block.

## Test plan
- Empty message (one beat, `in_last`=1, `in_empty`=1) -> one `core_start`; block byte0=0x06, byte135=0x80, all other bytes 0; then `digest_valid` with the core digest.
- "abc" (0x61,0x62,0x63, last on 0x63) -> block bytes 0..3 = 61 62 63 06; byte135=0x80; single absorb.
- 135-byte message -> one block, byte134 = last data byte, byte135=0x86. With `KECCAK_LEGACY_PAD_EN`, byte135=0x81.
- 136-byte message -> two `core_start` pulses; the second block is pad-only (byte0=0x06, byte135=0x80).
- 300 bytes with random `in_valid` gaps, and `digest_ready` held low 10 cycles -> 3 absorbs, `digest` stable while held, `core_init` pulse on accept, then a second message hashes correctly.
- `reset_n` low for 1 cycle after 50 bytes -> `in_ready`=0 and `core_init`=1 during reset; the following 3-byte message produces the same block as the "abc" case.
